// File: rtl/tl_handshake_protocol_checker_if.sv
// Ready/valid bundle for NCH monitored channels.
// master drives the channels, slave observes them (the checker).
interface tl_handshake_protocol_checker_if #(
  parameter int NCH    = 3,
  parameter int DATA_W = 16
);
  logic [NCH-1:0]        ch_valid;
  logic [NCH-1:0]        ch_ready;
  logic [NCH*DATA_W-1:0] ch_payload;

  modport master (
    output ch_valid,
    output ch_ready,
    output ch_payload
  );

  modport slave (
    input ch_valid,
    input ch_ready,
    input ch_payload
  );
endinterface

// File: rtl/tl_handshake_protocol_checker.sv
// Sequential ready/valid protocol checker for NCH channels.
// Ports: clock, reset_n, enable, clear, bus (slave), err_* reports, outstanding.
`ifndef PRINTF_COND
`define PRINTF_COND 1'b1
`endif

module tl_handshake_protocol_checker #(
  parameter int NCH     = 3,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64,
  parameter int MAX_OUT = 8,
  parameter int REQ_CH  = 0,
  parameter int RSP_CH  = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  tl_handshake_protocol_checker_if.slave bus,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic [3:0]       err_chan,
  output logic [4:0]       err_sticky,
  output logic [NCH-1:0]   err_chan_mask,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       outstanding
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIM    = TW'(TIMEOUT);
  localparam logic [TW-1:0] LIM_M1 = TW'(TIMEOUT - 1);
  localparam bit            PAIR   = (REQ_CH != RSP_CH);
  localparam logic [7:0]    MAXO   = 8'(MAX_OUT);

  logic                         r_hv;
  logic [NCH-1:0]               r_pv;
  logic [NCH-1:0]               r_pr;
  logic [NCH-1:0][DATA_W-1:0]   r_pd;
  logic [NCH-1:0][TW-1:0]       r_stall;
  logic [7:0]                   r_out;
  logic                         r_err_valid;
  logic [2:0]                   r_err_code;
  logic [3:0]                   r_err_chan;
  logic [4:0]                   r_err_sticky;
  logic [NCH-1:0]               r_err_mask;
  logic [CNT_W-1:0]             r_err_count;

  logic [NCH-1:0][DATA_W-1:0]   w_pl;
  logic [NCH-1:0]               w_valid;
  logic [NCH-1:0]               w_ready;
  logic [NCH-1:0]               w_fire;
  logic [NCH-1:0][4:0]          w_err;
  logic [NCH-1:0][TW-1:0]       w_stall_nxt;
  logic                         w_req;
  logic                         w_rsp;
  logic                         w_ovf;
  logic                         w_unf;
  logic [7:0]                   w_out_nxt;
  logic                         w_any;
  logic [2:0]                   w_code;
  logic [3:0]                   w_chan;
  logic [4:0]                   w_codes;
  logic [NCH-1:0]               w_mask;

  assign w_pl    = bus.ch_payload;
  assign w_valid = bus.ch_valid;
  assign w_ready = bus.ch_ready;
  assign w_fire  = w_valid & w_ready;

  always_comb begin
    w_err       = '0;
    w_stall_nxt = r_stall;
    w_req       = 1'b0;
    w_rsp       = 1'b0;
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
    w_out_nxt   = r_out;
    w_any       = 1'b0;
    w_code      = 3'd0;
    w_chan      = 4'd0;
    w_codes     = '0;
    w_mask      = '0;

    for (int i = 0; i < NCH; i++) begin
      w_err[i][0] = r_pv[i] & ~r_pr[i] & ~w_valid[i];
      w_err[i][1] = r_pv[i] & ~r_pr[i] & w_valid[i]
                  & (w_pl[i] != r_pd[i]);
      if (TIMEOUT != 0) begin
        if (w_valid[i] & ~w_ready[i]) begin
          // fires only on the step into the limit, so once per episode
          w_err[i][2] = (r_stall[i] == LIM_M1);
          if (r_stall[i] != LIM)
            w_stall_nxt[i] = r_stall[i] + 1'b1;
        end else begin
          w_stall_nxt[i] = '0;
        end
      end
    end

    if (PAIR) begin
      w_req = w_fire[REQ_CH];
      w_rsp = w_fire[RSP_CH];
      w_ovf = w_req & ~w_rsp & (r_out == MAXO);
      w_unf = w_rsp & ~w_req & (r_out == 8'd0);
      w_err[REQ_CH][3] = w_ovf;
      w_err[RSP_CH][4] = w_unf;
      if (w_req & ~w_rsp & ~w_ovf)
        w_out_nxt = r_out + 8'd1;
      else if (w_rsp & ~w_req & ~w_unf)
        w_out_nxt = r_out - 8'd1;
    end

    // history still tracks while disarmed; only reporting is suppressed
    if (!(enable & r_hv))
      w_err = '0;

    for (int i = 0; i < NCH; i++) begin
      for (int c = 0; c < 5; c++) begin
        if (w_err[i][c]) begin
          w_codes[c] = 1'b1;
          w_mask[i]  = 1'b1;
          if (!w_any) begin
            w_any  = 1'b1;
            w_code = 3'(c);
            w_chan = 4'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hv         <= 1'b0;
      r_pv         <= '0;
      r_pr         <= '0;
      r_pd         <= '0;
      r_stall      <= '0;
      r_out        <= '0;
      r_err_valid  <= 1'b0;
      r_err_code   <= '0;
      r_err_chan   <= '0;
      r_err_sticky <= '0;
      r_err_mask   <= '0;
      r_err_count  <= '0;
    end else begin
      r_hv        <= 1'b1;
      r_pv        <= w_valid;
      r_pr        <= w_ready;
      r_pd        <= w_pl;
      r_stall     <= w_stall_nxt;
      r_out       <= w_out_nxt;
      r_err_valid <= w_any;
      if (w_any) begin
        r_err_code <= w_code;
        r_err_chan <= w_chan;
      end
      if (clear) begin
        r_err_sticky <= '0;
        r_err_mask   <= '0;
        r_err_count  <= '0;
      end else begin
        r_err_sticky <= r_err_sticky | w_codes;
        r_err_mask   <= r_err_mask | w_mask;
        if (w_any && (r_err_count != '1))
          r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign err_valid     = r_err_valid;
  assign err_code      = r_err_code;
  assign err_chan      = r_err_chan;
  assign err_sticky    = r_err_sticky;
  assign err_chan_mask = r_err_mask;
  assign err_count     = r_err_count;
  assign outstanding   = r_out;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset_n && w_any && `PRINTF_COND)
      $display("tl_handshake_protocol_checker: event code=%0d chan=%0d",
        w_code, w_chan);
  end
`endif

endmodule

// File: tb/tb_tl_handshake_protocol_checker.sv
// Bench for tl_handshake_protocol_checker: vector table + scoreboard queue.
// Small TIMEOUT/MAX_OUT so stall and outstanding limits are reachable.
module tb_tl_handshake_protocol_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       clear;
  logic       err_valid;
  logic [2:0] err_code;
  logic [3:0] err_chan;
  logic [4:0] err_sticky;
  logic [2:0] err_chan_mask;
  logic [7:0] err_count;
  logic [7:0] outstanding;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tl_handshake_protocol_checker_if #(.NCH(3), .DATA_W(16)) bus ();

  tl_handshake_protocol_checker #(
    .NCH(3), .DATA_W(16), .TIMEOUT(4), .MAX_OUT(2),
    .REQ_CH(0), .RSP_CH(1), .CNT_W(8)
  ) dut (
    .clock        (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .clear        (clear),
    .bus          (bus),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .err_chan     (err_chan),
    .err_sticky   (err_sticky),
    .err_chan_mask(err_chan_mask),
    .err_count    (err_count),
    .outstanding  (outstanding)
  );

  typedef struct {
    string      nm;
    bit         en;
    bit         clr;
    logic [2:0] v;
    logic [2:0] r;
    logic [47:0] pl;
    bit         ev;
    logic [2:0] ec;
    logic [3:0] ech;
    logic [4:0] st;
    logic [2:0] mk;
    logic [7:0] cnt;
    logic [7:0] out;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(
    input string nm, input bit en, input bit clr,
    input logic [2:0] v, input logic [2:0] r,
    input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
    input bit ev, input logic [2:0] ec, input logic [3:0] ech,
    input logic [4:0] st, input logic [2:0] m,
    input logic [7:0] cnt, input logic [7:0] out);
    vec_t t;
    t.nm = nm; t.en = en; t.clr = clr; t.v = v; t.r = r;
    t.pl = {p2, p1, p0};
    t.ev = ev; t.ec = ec; t.ech = ech; t.st = st;
    t.mk = m; t.cnt = cnt; t.out = out;
    return t;
  endfunction

  function automatic void add(
    input string nm, input bit en, input bit clr,
    input logic [2:0] v, input logic [2:0] r,
    input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
    input bit ev, input logic [2:0] ec, input logic [3:0] ech,
    input logic [4:0] st, input logic [2:0] m,
    input logic [7:0] cnt, input logic [7:0] out);
    tbl.push_back(mk(nm, en, clr, v, r, p0, p1, p2,
                     ev, ec, ech, st, m, cnt, out));
  endfunction

  task automatic drive(input vec_t t);
    @(negedge clk);
    enable         = t.en;
    clear          = t.clr;
    bus.ch_valid   = t.v;
    bus.ch_ready   = t.r;
    bus.ch_payload = t.pl;
    sb.push_back(t);
  endtask

  task automatic check(input vec_t e);
    bit bad;
    n_assert++;
    bad = (err_valid !== e.ev) || (err_sticky !== e.st) ||
          (err_chan_mask !== e.mk) || (err_count !== e.cnt) ||
          (outstanding !== e.out);
    if (e.ev && ((err_code !== e.ec) || (err_chan !== e.ech)))
      bad = 1'b1;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got v=%0b code=%0d chan=%0d st=%b mk=%b cnt=%0d out=%0d want v=%0b code=%0d chan=%0d st=%b mk=%b cnt=%0d out=%0d",
        e.nm, err_valid, err_code, err_chan, err_sticky, err_chan_mask,
        err_count, outstanding, e.ev, e.ec, e.ech, e.st, e.mk,
        e.cnt, e.out);
    end
  endtask

  task automatic chk_zero(input string nm);
    n_assert++;
    if ({err_valid, err_code, err_chan, err_sticky, err_chan_mask,
         err_count, outstanding} !== 32'd0) begin
      n_fail++;
      $display("FAIL %s: got v=%0b code=%0d chan=%0d st=%b mk=%b cnt=%0d out=%0d want all zero",
        nm, err_valid, err_code, err_chan, err_sticky, err_chan_mask,
        err_count, outstanding);
    end
  endtask

  // outputs settle 1 time unit after the edge that registers them
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) check(sb.pop_front());
  end

  initial begin
    reset_n        = 1'b0;
    enable         = 1'b1;
    clear          = 1'b0;
    bus.ch_valid   = '0;
    bus.ch_ready   = '0;
    bus.ch_payload = '0;

    // idle
    add("idle", 1,0, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    // valid drop on ch0
    add("drop_a1", 1,0, 3'b001,3'b000, 16'h1234,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    add("drop_a2", 1,0, 3'b001,3'b000, 16'h1234,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    add("drop_err", 1,0, 3'b000,3'b000, 0,0,0, 1,0,0, 5'h01,3'b001, 1,0);
    add("clr_a", 1,1, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    // payload change on ch1
    add("pchg_b1", 1,0, 3'b010,3'b000, 0,16'hAAAA,0, 0,0,0, 5'h00,3'b000, 0,0);
    add("pchg_err", 1,0, 3'b010,3'b000, 0,16'h5555,0, 1,1,1, 5'h02,3'b010, 1,0);
    add("both_fire", 1,0, 3'b011,3'b011, 0,16'h5555,0, 0,0,0, 5'h02,3'b010, 1,0);
    add("idle_b", 1,0, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h02,3'b010, 1,0);
    add("clr_b", 1,1, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    // stall on ch2, TIMEOUT=4
    for (int k = 1; k <= 10; k++) begin
      if (k < 4)
        add("stall_pre", 1,0, 3'b100,3'b000, 0,0,16'h0042, 0,0,0, 5'h00,3'b000, 0,0);
      else if (k == 4)
        add("stall_err", 1,0, 3'b100,3'b000, 0,0,16'h0042, 1,2,2, 5'h04,3'b100, 1,0);
      else
        add("stall_once", 1,0, 3'b100,3'b000, 0,0,16'h0042, 0,0,0, 5'h04,3'b100, 1,0);
    end
    add("stall_fire", 1,0, 3'b100,3'b100, 0,0,16'h0042, 0,0,0, 5'h04,3'b100, 1,0);
    add("clr_c", 1,1, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    // outstanding, MAX_OUT=2
    add("req1", 1,0, 3'b001,3'b001, 0,0,0, 0,0,0, 5'h00,3'b000, 0,1);
    add("req2", 1,0, 3'b001,3'b001, 0,0,0, 0,0,0, 5'h00,3'b000, 0,2);
    add("ovf", 1,0, 3'b001,3'b001, 0,0,0, 1,3,0, 5'h08,3'b001, 1,2);
    add("idle_d", 1,0, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h08,3'b001, 1,2);
    add("rsp1", 1,0, 3'b010,3'b010, 0,0,0, 0,0,0, 5'h08,3'b001, 1,1);
    add("rsp2", 1,0, 3'b010,3'b010, 0,0,0, 0,0,0, 5'h08,3'b001, 1,0);
    add("unf", 1,0, 3'b010,3'b010, 0,0,0, 1,4,1, 5'h18,3'b011, 2,0);
    add("clr_d", 1,1, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    // simultaneous: ch0 drop + ch2 payload change
    add("multi_1", 1,0, 3'b101,3'b000, 16'h1111,0,16'h2222, 0,0,0, 5'h00,3'b000, 0,0);
    add("multi_err", 1,0, 3'b100,3'b000, 0,0,16'h3333, 1,0,0, 5'h03,3'b101, 1,0);
    add("multi_fire", 1,0, 3'b100,3'b100, 0,0,16'h3333, 0,0,0, 5'h03,3'b101, 1,0);
    // clear beats a same-cycle error
    add("clrw_1", 1,0, 3'b001,3'b000, 16'h7777,0,0, 0,0,0, 5'h03,3'b101, 1,0);
    add("clrw_err", 1,1, 3'b000,3'b000, 0,0,0, 1,0,0, 5'h00,3'b000, 0,0);
    // disarmed: no reports, outstanding still tracks
    add("dis_1", 0,0, 3'b001,3'b000, 0,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    add("dis_drop", 0,0, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    add("dis_req", 0,0, 3'b001,3'b001, 0,0,0, 0,0,0, 5'h00,3'b000, 0,1);
    add("arm_idle", 1,0, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h00,3'b000, 0,1);
    add("arm_rsp", 1,0, 3'b010,3'b010, 0,0,0, 0,0,0, 5'h00,3'b000, 0,0);
    // err_count saturation at 255
    for (int k = 1; k <= 260; k++) begin
      add("sat_hold", 1,0, 3'b001,3'b000, 0,0,0, 0,0,0,
          (k == 1) ? 5'h00 : 5'h01, (k == 1) ? 3'b000 : 3'b001,
          8'((k - 1 > 255) ? 255 : k - 1), 0);
      add("sat_drop", 1,0, 3'b000,3'b000, 0,0,0, 1,0,0, 5'h01,3'b001,
          8'((k > 255) ? 255 : k), 0);
    end
    add("clr_h", 1,1, 3'b000,3'b000, 0,0,0, 0,0,0, 5'h00,3'b000, 0,0);

    repeat (2) @(negedge clk);
    chk_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) drive(tbl[i]);

    // reset in the middle of a ch2 stall with live state
    drive(mk("r_req", 1,0, 3'b001,3'b001, 0,0,0, 0,0,0, 5'h00,3'b000, 0,1));
    drive(mk("r_st1", 1,0, 3'b100,3'b000, 0,0,16'h0005, 0,0,0, 5'h00,3'b000, 0,1));
    drive(mk("r_st2", 1,0, 3'b100,3'b000, 0,0,16'h0005, 0,0,0, 5'h00,3'b000, 0,1));
    drive(mk("r_pchg", 1,0, 3'b100,3'b000, 0,0,16'h0006, 1,1,2, 5'h02,3'b100, 1,1));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    // first cycle after release: ch1 rsp at outstanding 0 must stay silent
    drive(mk("post_c1", 1,0, 3'b110,3'b010, 0,0,16'h0006, 0,0,0, 5'h00,3'b000, 0,0));
    reset_n = 1'b1;
    drive(mk("post_c2", 1,0, 3'b100,3'b000, 0,0,16'h0006, 0,0,0, 5'h00,3'b000, 0,0));
    drive(mk("post_c3", 1,0, 3'b100,3'b000, 0,0,16'h0006, 0,0,0, 5'h00,3'b000, 0,0));
    drive(mk("post_stall", 1,0, 3'b100,3'b000, 0,0,16'h0006, 1,2,2, 5'h04,3'b100, 1,0));
    drive(mk("post_fire", 1,0, 3'b100,3'b100, 0,0,16'h0006, 0,0,0, 5'h04,3'b100, 1,0));

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
